// File: rtl/pipe_adder_n.sv
// Chunked pipelined adder/subtractor with valid/ready handshake and a global advance enable.
// Optional signed saturation of the final sum when PIPE_ADDER_SAT_EN is defined.
module pipe_adder_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ofl
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             en_s;
    logic             v_r     [STAGES];
    logic [WIDTH-1:0] a_r     [STAGES];
    logic [WIDTH-1:0] b_r     [STAGES];
    logic [WIDTH-1:0] s_r     [STAGES];
    logic             c_r     [STAGES];
    logic [CHUNK:0]   chunk_s [STAGES];
    logic [WIDTH-1:0] s_nxt_s [STAGES];
    logic             c_nxt_s [STAGES];
    logic [WIDTH-1:0] raw_sum_s;
    logic [WIDTH-1:0] res_sum_s;
    logic             raw_cout_s;
    logic             msb_cin_s;
    logic             raw_ofl_s;

    // Whole pipe advances together; a held output freezes every stage.
    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    // Per-stage chunk addition: stage k fills bits of chunk k and produces its carry.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk_s[k] = {1'b0, a_r[k][k*CHUNK +: CHUNK]}
                       + {1'b0, b_r[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, c_r[k]};
            s_nxt_s[k] = s_r[k];
            s_nxt_s[k][k*CHUNK +: CHUNK] = chunk_s[k][CHUNK-1:0];
            c_nxt_s[k] = chunk_s[k][CHUNK];
        end
    end

    // Final result: carry into the MSB is recovered from the MSB sum bit and its operands.
    always_comb begin
        raw_sum_s  = s_nxt_s[STAGES-1];
        raw_cout_s = c_nxt_s[STAGES-1];
        msb_cin_s  = a_r[STAGES-1][WIDTH-1] ^ b_r[STAGES-1][WIDTH-1] ^ raw_sum_s[WIDTH-1];
        raw_ofl_s  = msb_cin_s ^ raw_cout_s;
        res_sum_s  = raw_sum_s;
`ifdef PIPE_ADDER_SAT_EN
        if (raw_ofl_s) begin
            if (a_r[STAGES-1][WIDTH-1]) begin
                res_sum_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res_sum_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res_sum_s = raw_sum_s;
        end
`else
        res_sum_s = raw_sum_s;
`endif
    end

    // Stage registers and output register; B and Cin are inverted at entry for subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                a_r[k] <= {WIDTH{1'b0}};
                b_r[k] <= {WIDTH{1'b0}};
                s_r[k] <= {WIDTH{1'b0}};
                c_r[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            S         <= {WIDTH{1'b0}};
            Cout      <= 1'b0;
            Ofl       <= 1'b0;
        end else if (en_s) begin
            v_r[0] <= in_valid;
            a_r[0] <= A;
            b_r[0] <= sub ? ~B : B;
            s_r[0] <= {WIDTH{1'b0}};
            c_r[0] <= sub ? ~Cin : Cin;
            for (int k = 1; k < STAGES; k++) begin
                v_r[k] <= v_r[k-1];
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
                s_r[k] <= s_nxt_s[k-1];
                c_r[k] <= c_nxt_s[k-1];
            end
            out_valid <= v_r[STAGES-1];
            S         <= res_sum_s;
            Cout      <= raw_cout_s;
            Ofl       <= raw_ofl_s;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_pipe_adder_n.sv
// Directed bench for pipe_adder_n (16/4 instance) plus a 32/8 instance driven by a random stream
// against an arithmetic reference model.
module tb_pipe_adder_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ofl;
    logic [15:0] a, b, s;
    logic        in_valid_w, in_ready_w, cin_w, sub_w, out_valid_w, out_ready_w, cout_w, ofl_w;
    logic [31:0] a_w, b_w, s_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sent, got;
    logic        acc, take;
    logic [15:0] held;
    logic [31:0] bb, ms;
    logic        mc, mo, c0;
    logic [33:0] exp_w;
    logic [33:0] q [$];

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [15:0] EXP_POS_OFL = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_OFL = 16'h8000;
`else
    localparam logic [15:0] EXP_POS_OFL = 16'h8000;
    localparam logic [15:0] EXP_NEG_OFL = 16'h7FFF;
`endif

    always #5 clk = ~clk;

    pipe_adder_n #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(s), .Cout(cout), .Ofl(ofl)
    );

    pipe_adder_n #(.WIDTH(32), .CHUNK(8)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .A(a_w), .B(b_w), .Cin(cin_w), .sub(sub_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .S(s_w), .Cout(cout_w), .Ofl(ofl_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xs);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        sub = xs;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid_w = 1'b0; a_w = 32'h0; b_w = 32'h0; cin_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b1;
        #2;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_S", s, 16'h0000);
        check("reset_cout_ofl", {cout, ofl}, 2'b00);
        check("reset_out_valid_w", out_valid_w, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // Single transfer: latency and one-cycle out_valid pulse
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lat_early_valid", out_valid, 1'b0);
        end
        tick();
        check("single_valid", out_valid, 1'b1);
        check("single_S", s, 16'h0100);
        check("single_cout_ofl", {cout, ofl}, 2'b00);
        tick();
        check("single_pulse_end", out_valid, 1'b0);

        // Back-to-back transfers
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h1234, 16'h1234, 1'b0, 1'b1);
        tick();
        tick();
        check("b2b0", {out_valid, s, cout, ofl}, {1'b1, 16'h0000, 1'b1, 1'b0});
        tick();
        check("b2b1", {out_valid, s, cout, ofl}, {1'b1, EXP_POS_OFL, 1'b0, 1'b1});
        tick();
        check("b2b2", {out_valid, s, cout, ofl}, {1'b1, 16'h0000, 1'b1, 1'b0});
        tick();

        // Subtraction with negative overflow and with borrow-in
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0005, 16'h0003, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        check("sub_ofl", {out_valid, s, cout, ofl}, {1'b1, EXP_NEG_OFL, 1'b1, 1'b1});
        tick();
        check("sub_borrow", {out_valid, s, cout}, {1'b1, 16'h0001, 1'b1});
        tick();

        // Six-transfer stream with a three-cycle output stall
        sent = 0;
        got = 0;
        held = 16'h0000;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid = (sent < 6);
            a = 16'(16'h0100 * (sent + 1));
            b = 16'(16'h0011 * (sent + 1));
            cin = 1'b0;
            sub = 1'b0;
            out_ready = !(c >= 6 && c <= 8);
            #1;
            if (c == 6) held = s;
            if (c >= 6 && c <= 8) begin
                check("stall_out_valid", out_valid, 1'b1);
                check("stall_in_ready", in_ready, 1'b0);
                check("stall_hold_S", s, held);
            end
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                check("stream_S", s, 16'(16'h0111 * (got + 1)));
                got++;
            end
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 6);
        check("stream_sent", sent, 6);
        tick();
        check("stream_no_dup", out_valid, 1'b0);

        // Reset with an operation in flight
        send(16'h0005, 16'h0003, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #2;
        check("inflight_rst_valid", out_valid, 1'b0);
        check("inflight_rst_ready", in_ready, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("inflight_discard", out_valid, 1'b0);
        end
        send(16'h0002, 16'h0002, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("post_rst_early", out_valid, 1'b0);
        tick();
        check("post_rst_result", {out_valid, s}, {1'b1, 16'h0004});
        tick();

        // 32-bit / 8-bit-chunk instance: random stream against reference model
        sent = 0;
        got = 0;
        a_w = $urandom; b_w = $urandom; cin_w = 1'($urandom_range(0, 1)); sub_w = 1'($urandom_range(0, 1));
        in_valid_w = 1'b1;
        out_ready_w = 1'b1;
        for (int c = 0; c < 1000 && got < 40; c++) begin
            #1;
            acc = in_valid_w && in_ready_w;
            take = out_valid_w && out_ready_w;
            if (take) begin
                check("rand_expected_pending", (q.size() > 0), 1'b1);
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                    check("rand_result", {cout_w, ofl_w, s_w}, exp_w);
                end
                got++;
            end
            if (acc) begin
                bb = sub_w ? ~b_w : b_w;
                c0 = sub_w ? ~cin_w : cin_w;
                {mc, ms} = {1'b0, a_w} + {1'b0, bb} + {32'h0, c0};
                mo = (a_w[31] == bb[31]) && (ms[31] != a_w[31]);
`ifdef PIPE_ADDER_SAT_EN
                if (mo) ms = a_w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
                q.push_back({mc, mo, ms});
            end
            tick();
            if (acc) begin
                sent++;
                a_w = $urandom; b_w = $urandom;
                cin_w = 1'($urandom_range(0, 1)); sub_w = 1'($urandom_range(0, 1));
            end
            in_valid_w = (sent < 40) && ($urandom_range(0, 3) != 0);
            out_ready_w = ($urandom_range(0, 3) != 0);
        end
        in_valid_w = 1'b0;
        check("rand_count", got, 40);
        check("rand_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder_n.md
PIPE_ADDER_N -- requirements
Module: pipe_adder_n

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter: CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand set present.
REQ-006 Port: in_ready  output  1  operand set accepted when in_valid && in_ready.
REQ-007 Port: A  input  WIDTH  operand A.
REQ-008 Port: B  input  WIDTH  operand B.
REQ-009 Port: Cin  input  1  carry-in (borrow-in when sub=1).
REQ-010 Port: sub  input  1  0 = add, 1 = subtract.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 Port: S  output  WIDTH  result.
REQ-014 Port: Cout  output  1  carry-out of bit WIDTH-1 (raw, before any saturation).
REQ-015 Port: Ofl  output  1  signed two's-complement overflow.

Function
REQ-016 Effective operands SHALL be B' = sub ? ~B : B and c0 = sub ? ~Cin : Cin, so that sub=1 yields A - B - Cin.
REQ-017 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK+CHUNK-1 : k*CHUNK] of A and B' with the carry registered by stage k-1 (c0 for stage 0); the upper operand bits and the partial sum SHALL be carried forward in registers.
REQ-018 Latency SHALL be exactly STAGES cycles: a transfer accepted on edge N SHALL present out_valid=1 with its result after edge N+STAGES when out_ready stays high.
REQ-019 A global advance enable SHALL exist: en = !out_valid || out_ready; all stage registers, including valid bits, SHALL shift only when en=1.
REQ-020 in_ready SHALL equal en (combinational); there SHALL be no combinational path from in_valid to in_ready.
REQ-021 When out_valid=1 and out_ready=0, S, Cout, Ofl and out_valid SHALL hold unchanged, and no input SHALL be accepted.
REQ-022 Bubbles SHALL propagate as stages with valid=0; they need not be collapsed.
REQ-023 Throughput SHALL be one result per cycle while in_valid=1 and out_ready=1.
REQ-024 Ofl SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-025 S, Cout and Ofl SHALL be don't-care while out_valid=0; they SHALL change only when en=1.

Reset
REQ-026 rst=1 SHALL asynchronously clear every stage valid bit, out_valid, S, Cout and Ofl to 0.
REQ-027 Operations in flight when rst asserts SHALL be discarded; no result SHALL emerge after rst deasserts.
REQ-028 in_ready SHALL be 1 during and after reset (no valid data held).

Configuration
REQ-029 Macro PIPE_ADDER_SAT_EN: when defined, a final result with Ofl=1 SHALL clamp S to the signed maximum (0111..1) for positive overflow (A[WIDTH-1]=0) or the signed minimum (1000..0) for negative overflow; Cout and Ofl SHALL remain raw.
REQ-030 When PIPE_ADDER_SAT_EN is undefined, S SHALL wrap modulo 2^WIDTH; latency and handshake SHALL be identical in both builds.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-031 A=0x00FF, B=0x0001, Cin=0, sub=0, out_ready=1 -> 4 cycles later S=0x0100, Cout=0, Ofl=0, out_valid high for 1 cycle.
REQ-032 Back-to-back 0xFFFF+0x0001, 0x7FFF+0x0001, 0x1234-0x1234 (sub=1, Cin=0) -> consecutive cycles S=0x0000/Cout=1/Ofl=0, S=0x8000 (0x7FFF with SAT_EN)/Ofl=1, S=0x0000/Cout=1/Ofl=0.
REQ-033 Stream 6 transfers, drop out_ready for 3 cycles mid-stream -> in_ready=0 and S held during stall, all 6 results in order, none lost or duplicated.
REQ-034 Assert rst 2 cycles after accepting 0x0005+0x0003 -> out_valid stays 0, no result ever appears; next operation 0x0002+0x0002 gives S=0x0004 after 4 cycles.
REQ-035 sub=1, A=0x8000, B=0x0001, Cin=0 -> S=0x7FFF, Ofl=1 (0x8000 with SAT_EN); sub=1, A=0x0005, B=0x0003, Cin=1 -> S=0x0001.
REQ-036 Random A/B/Cin/sub with random in_valid/out_ready, WIDTH=32, CHUNK=8 -> every result matches a reference model, in order.
